// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR-flash responder: opcodes, FSM states, status bits.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_PP        = 8'h02;
    localparam logic [7:0] OP_SE        = 8'h20;
    localparam logic [7:0] OP_RDSR      = 8'h05;
    localparam logic [7:0] OP_WREN      = 8'h06;
    localparam logic [7:0] OP_WRDI      = 8'h04;
    localparam logic [7:0] OP_JEDEC     = 8'h9F;

    localparam int unsigned ST_WIP   = 0;
    localparam int unsigned ST_WEL   = 1;
    localparam int unsigned SECTOR_W = 12;

    typedef enum logic [3:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StRdData,
        StWrData,
        StStat,
        StId,
        StIgnore
    } state_e;

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchronisers for SCK, CSn and MOSI plus edge pulses on SCK and CSn.
// A third SCK/CSn stage holds the previous synchronised level for edge detection.
module spi_target_sync (
    input  logic clk,
    input  logic reset,
    input  logic sck_i,
    input  logic csn_i,
    input  logic mosi_i,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic cs_fall_o,
    output logic cs_rise_o,
    output logic mosi_o
);

    logic [2:0] sck_q;
    logic [2:0] csn_q;
    logic [1:0] mosi_q;

    // Shift the raw pins through the synchroniser chains; CSn idles deasserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q  <= 3'b000;
            csn_q  <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], sck_i};
            csn_q  <= {csn_q[1:0], csn_i};
            mosi_q <= {mosi_q[0], mosi_i};
        end
    end

    assign sck_rise_o = sck_q[1] & ~sck_q[2];
    assign sck_fall_o = ~sck_q[1] & sck_q[2];
    assign cs_fall_o  = ~csn_q[1] & csn_q[2];
    assign cs_rise_o  = csn_q[1] & ~csn_q[2];
    assign mosi_o     = mosi_q[1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 target emulating a 24-bit-address NOR flash on a byte-wide memory port.
// Optional fast read (0x0B with 8 dummy clocks) is enabled by SPI_FLASH_RESP_FAST_READ_EN.
// ADDR_W is expected to be at most 24.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int unsigned ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018,
    parameter int unsigned PAGE_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_csel,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_req,
    input  logic [7:0]        mem_rd_data,
    input  logic              mem_rd_valid,
    output logic              mem_wr_req,
    output logic [7:0]        mem_wr_data,
    output logic              mem_erase_req,
    input  logic              mem_ack,
    output logic [7:0]        status
);

    logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;

    spi_target_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .sck_i     (spi_clk),
        .csn_i     (spi_csel),
        .mosi_i    (spi_mosi),
        .sck_rise_o(sck_rise),
        .sck_fall_o(sck_fall),
        .cs_fall_o (cs_fall),
        .cs_rise_o (cs_rise),
        .mosi_o    (mosi_s)
    );

    state_e            state_q;
    logic [4:0]        bit_cnt_q;
    logic [5:0]        tot_q;      // SCK rises since CSn fall, saturating
    logic [2:0]        tx_cnt_q;
    logic [6:0]        sr_q;
    logic [22:0]       addr_sr_q;
    logic [7:0]        op_q, tx_sr_q, rd_buf_q, wr_data_q;
    logic [ADDR_W-1:0] addr_q, mem_addr_q;
    logic [1:0]        id_idx_q;
    logic              wel_q, wip_q, prog_cmd_q, erase_cmd_q;
    logic              miso_q, oe_q, rd_req_q, wr_req_q, erase_req_q;

    logic [7:0]        rx_byte, tx_byte, status_w, id_byte;
    logic [23:0]       addr_full;
    logic [ADDR_W-1:0] addr_in, page_next;
    logic              byte_done, raise_wr, raise_erase;

    assign rx_byte     = {sr_q, mosi_s};
    assign addr_full   = {addr_sr_q, mosi_s};
    assign addr_in     = addr_full[ADDR_W-1:0];
    assign page_next   = {addr_q[ADDR_W-1:PAGE_W], addr_q[PAGE_W-1:0] + PAGE_W'(1)};
    assign byte_done   = sck_rise & (bit_cnt_q[2:0] == 3'd7);
    // A byte completing while the previous write is still outstanding is dropped.
    assign raise_wr    = (state_q == StWrData) & byte_done & ~(wr_req_q & ~mem_ack);
    assign raise_erase = cs_rise & erase_cmd_q & (tot_q == 6'd32);

    // Status byte and the byte to launch next on MISO for the current state.
    always_comb begin
        status_w         = '0;
        status_w[ST_WIP] = wip_q;
        status_w[ST_WEL] = wel_q;
        case (id_idx_q)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'hFF;
        endcase
        case (state_q)
            StRdData: tx_byte = rd_buf_q;
            StStat:   tx_byte = status_w;
            StId:     tx_byte = id_byte;
            default:  tx_byte = 8'h00;
        endcase
    end

    // Command FSM, shift registers and registered memory/SPI outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            tot_q       <= '0;
            tx_cnt_q    <= '0;
            sr_q        <= '0;
            addr_sr_q   <= '0;
            op_q        <= '0;
            tx_sr_q     <= '0;
            rd_buf_q    <= '0;
            wr_data_q   <= '0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            id_idx_q    <= '0;
            wel_q       <= 1'b0;
            prog_cmd_q  <= 1'b0;
            erase_cmd_q <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            erase_req_q <= 1'b0;
        end else begin
            rd_req_q <= 1'b0;
            if (mem_rd_valid) rd_buf_q <= mem_rd_data;
            if (mem_ack) begin
                wr_req_q    <= 1'b0;
                erase_req_q <= 1'b0;
            end
            if (sck_rise) begin
                sr_q      <= rx_byte[6:0];
                addr_sr_q <= addr_full[22:0];
                bit_cnt_q <= bit_cnt_q + 5'd1;
                if (tot_q != 6'h3F) tot_q <= tot_q + 6'd1;
            end

            if (cs_rise) begin
                state_q     <= StIdle;
                oe_q        <= 1'b0;
                prog_cmd_q  <= 1'b0;
                erase_cmd_q <= 1'b0;
                if (prog_cmd_q) wel_q <= 1'b0;
                if (raise_erase) begin
                    erase_req_q <= 1'b1;
                    mem_addr_q  <= {addr_q[ADDR_W-1:SECTOR_W], SECTOR_W'(0)};
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        if (cs_fall) begin
                            state_q   <= StCmd;
                            bit_cnt_q <= '0;
                            tot_q     <= '0;
                            tx_cnt_q  <= '0;
                            id_idx_q  <= '0;
                        end
                    end
                    StCmd: begin
                        if (byte_done) begin
                            bit_cnt_q <= '0;
                            op_q      <= rx_byte;
                            if (wip_q && rx_byte != OP_RDSR) begin
                                state_q <= StIgnore;
                            end else begin
                                case (rx_byte)
                                    OP_READ:      state_q <= StAddr;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                                    OP_FAST_READ: state_q <= StAddr;
`endif
                                    OP_PP, OP_SE: begin
                                        if (wel_q) begin
                                            state_q     <= StAddr;
                                            prog_cmd_q  <= 1'b1;
                                            erase_cmd_q <= (rx_byte == OP_SE);
                                        end else begin
                                            state_q <= StIgnore;
                                        end
                                    end
                                    OP_RDSR: begin
                                        state_q <= StStat;
                                        oe_q    <= 1'b1;
                                    end
                                    OP_JEDEC: begin
                                        state_q <= StId;
                                        oe_q    <= 1'b1;
                                    end
                                    OP_WREN: begin
                                        wel_q   <= 1'b1;
                                        state_q <= StIgnore;
                                    end
                                    OP_WRDI: begin
                                        wel_q   <= 1'b0;
                                        state_q <= StIgnore;
                                    end
                                    default: state_q <= StIgnore;
                                endcase
                            end
                        end
                    end
                    StAddr: begin
                        if (sck_rise && bit_cnt_q == 5'd23) begin
                            bit_cnt_q <= '0;
                            addr_q    <= addr_in;
                            case (op_q)
                                OP_READ: begin
                                    state_q    <= StRdData;
                                    oe_q       <= 1'b1;
                                    rd_req_q   <= 1'b1;
                                    mem_addr_q <= addr_in;
                                end
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                                OP_FAST_READ: begin
                                    state_q    <= StDummy;
                                    rd_req_q   <= 1'b1;
                                    mem_addr_q <= addr_in;
                                end
`endif
                                OP_PP:   state_q <= StWrData;
                                default: state_q <= StIgnore;
                            endcase
                        end
                    end
                    StDummy: begin
                        if (byte_done) begin
                            bit_cnt_q <= '0;
                            state_q   <= StRdData;
                            oe_q      <= 1'b1;
                        end
                    end
                    StWrData: begin
                        if (byte_done) bit_cnt_q <= '0;
                        if (raise_wr) begin
                            wr_req_q   <= 1'b1;
                            wr_data_q  <= rx_byte;
                            mem_addr_q <= addr_q;
                            addr_q     <= page_next;
                        end
                    end
                    default: ;
                endcase

                // MISO launch on SCK fall; a new byte starts every eighth fall.
                if (sck_fall && (state_q == StRdData || state_q == StStat || state_q == StId)) begin
                    tx_cnt_q <= tx_cnt_q + 3'd1;
                    if (tx_cnt_q == 3'd0) begin
                        miso_q  <= tx_byte[7];
                        tx_sr_q <= {tx_byte[6:0], 1'b0};
                        if (state_q == StRdData) begin
                            // Prefetch the following byte while this one shifts out.
                            rd_req_q   <= 1'b1;
                            addr_q     <= addr_q + ADDR_W'(1);
                            mem_addr_q <= addr_q + ADDR_W'(1);
                        end
                        if (state_q == StId && id_idx_q != 2'd3) id_idx_q <= id_idx_q + 2'd1;
                    end else begin
                        miso_q  <= tx_sr_q[7];
                        tx_sr_q <= {tx_sr_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

    // WIP: set by any write/erase request, held while a request is outstanding or a
    // page program is still selected.
    always_ff @(posedge clk) begin
        if (reset) begin
            wip_q <= 1'b0;
        end else if (raise_wr || raise_erase) begin
            wip_q <= 1'b1;
        end else if (!wr_req_q && !erase_req_q && state_q != StWrData) begin
            wip_q <= 1'b0;
        end
    end

    assign spi_miso      = miso_q;
    assign spi_miso_oe   = oe_q;
    assign mem_addr      = mem_addr_q;
    assign mem_rd_req    = rd_req_q;
    assign mem_wr_req    = wr_req_q;
    assign mem_wr_data   = wr_data_q;
    assign mem_erase_req = erase_req_q;
    assign status        = status_w;

endmodule
